// File: rtl/aes_stream_sequencer.sv
// Sequences a shared aes_core: one key expansion, then one decryption per accepted
// ciphertext block, with each 128-bit plaintext serialised as a 1-bit stream.
module aes_stream_sequencer #(
  parameter int unsigned TIMEOUT   = 255,
  parameter bit          LSB_FIRST = 1'b1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [127:0] key_i,
  input  logic         key_load_i,
  output logic         key_ready_o,
  input  logic         blk_valid_i,
  input  logic [127:0] blk_data_i,
  output logic         blk_ready_o,
  output logic         bit_o,
  output logic         bit_valid_o,
  input  logic         shift_en_i,
  output logic         busy_o,
  output logic         err_o,
  output logic         aes_reset_n_o,
  output logic         aes_init_o,
  output logic         aes_next_o,
  output logic [127:0] aes_key_o,
  output logic [127:0] aes_block_o,
  input  logic [127:0] aes_result_i,
  input  logic         aes_result_valid_i,
  input  logic         aes_key_ready_i
);

  typedef enum logic [2:0] {
    StIdle,
    StKeyInit,
    StKeyWait,
    StReady,
    StDecStart,
    StDecWait,
    StShift
  } state_e;

  localparam logic [7:0] WaitLimit = 8'(TIMEOUT);

  state_e       r_state;
  logic [127:0] r_key;
  logic [127:0] r_block;
  logic [127:0] r_sr;
  logic [6:0]   r_bit_cnt;
  logic [7:0]   r_wait_cnt;
  logic         r_key_ready;
  logic         r_err;
  logic         r_busy;
  logic         r_bit_valid;
  logic         r_aes_init;
  logic         r_aes_next;
  logic         r_aes_reset_n;
  logic         r_rst_hold;

  logic w_wait_first;
  logic w_timeout;

  // The core's ready/valid may still reflect the previous operation on the first wait cycle.
  assign w_wait_first = (r_wait_cnt == 8'd0);
  assign w_timeout    = (r_wait_cnt == WaitLimit);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state       <= StIdle;
      r_key         <= '0;
      r_block       <= '0;
      r_sr          <= '0;
      r_bit_cnt     <= '0;
      r_wait_cnt    <= '0;
      r_key_ready   <= 1'b0;
      r_err         <= 1'b0;
      r_busy        <= 1'b0;
      r_bit_valid   <= 1'b0;
      r_aes_init    <= 1'b0;
      r_aes_next    <= 1'b0;
      r_aes_reset_n <= 1'b0;
      r_rst_hold    <= 1'b1;
    end else begin
      r_aes_init    <= 1'b0;
      r_aes_next    <= 1'b0;
      r_rst_hold    <= 1'b0;
      r_aes_reset_n <= ~r_rst_hold;
      unique case (r_state)
        StIdle: begin
          if (key_load_i) begin
            r_key      <= key_i;
            r_err      <= 1'b0;
            r_aes_init <= 1'b1;
            r_busy     <= 1'b1;
            r_state    <= StKeyInit;
          end
        end
        StKeyInit: begin
          r_wait_cnt <= '0;
          r_state    <= StKeyWait;
        end
        StKeyWait: begin
          if (!w_wait_first && aes_key_ready_i) begin
            r_key_ready <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= StReady;
          end else if (w_timeout) begin
            r_err         <= 1'b1;
            r_key_ready   <= 1'b0;
            r_busy        <= 1'b0;
            r_aes_reset_n <= 1'b0;
            r_state       <= StIdle;
          end else begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
          end
        end
        StReady: begin
          if (key_load_i) begin
            r_key       <= key_i;
            r_key_ready <= 1'b0;
            r_aes_init  <= 1'b1;
            r_busy      <= 1'b1;
            r_state     <= StKeyInit;
          end else if (blk_valid_i) begin
            r_block    <= blk_data_i;
            r_aes_next <= 1'b1;
            r_busy     <= 1'b1;
            r_state    <= StDecStart;
          end
        end
        StDecStart: begin
          r_wait_cnt <= '0;
          r_state    <= StDecWait;
        end
        StDecWait: begin
          if (!w_wait_first && aes_result_valid_i) begin
            r_sr        <= aes_result_i;
            r_bit_cnt   <= '0;
            r_bit_valid <= 1'b1;
            r_state     <= StShift;
          end else if (w_timeout) begin
            r_err         <= 1'b1;
            r_key_ready   <= 1'b0;
            r_busy        <= 1'b0;
            r_aes_reset_n <= 1'b0;
            r_state       <= StIdle;
          end else begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
          end
        end
        StShift: begin
          if (shift_en_i) begin
            if (LSB_FIRST) begin
              r_sr <= {1'b0, r_sr[127:1]};
            end else begin
              r_sr <= {r_sr[126:0], 1'b0};
            end
            r_bit_cnt <= r_bit_cnt + 7'd1;
            if (r_bit_cnt == 7'd127) begin
              r_bit_valid <= 1'b0;
              r_busy      <= 1'b0;
              r_state     <= StReady;
            end
          end
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  // A simultaneous key_load_i takes priority, so the block is never handshaken that cycle.
  assign blk_ready_o   = (r_state == StReady) && !key_load_i;
  assign key_ready_o   = r_key_ready;
  assign bit_o         = LSB_FIRST ? r_sr[0] : r_sr[127];
  assign bit_valid_o   = r_bit_valid;
  assign busy_o        = r_busy;
  assign err_o         = r_err;
  assign aes_reset_n_o = r_aes_reset_n;
  assign aes_init_o    = r_aes_init;
  assign aes_next_o    = r_aes_next;
  assign aes_key_o     = r_key;
  assign aes_block_o   = r_block;

endmodule

// File: tb/tb_aes_stream_sequencer.sv
// Randomised bench for aes_stream_sequencer: a behavioural aes_core stub plus a queue of
// expected serial bits derived from each accepted block and the key the bench loaded.
module tb_aes_stream_sequencer;

  localparam int unsigned  Timeout  = 255;
  localparam logic [127:0] KnownKey = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KnownCt  = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
  localparam logic [127:0] KnownPt  = 128'h6bc1bee22e409f96e93d7e117393172a;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b1;
  logic [127:0] key_i = '0;
  logic         key_load_i = 1'b0;
  logic         key_ready_o;
  logic         blk_valid_i = 1'b0;
  logic [127:0] blk_data_i = '0;
  logic         blk_ready_o;
  logic         bit_o;
  logic         bit_valid_o;
  logic         shift_en_i = 1'b0;
  logic         busy_o;
  logic         err_o;
  logic         aes_reset_n_o;
  logic         aes_init_o;
  logic         aes_next_o;
  logic [127:0] aes_key_o;
  logic [127:0] aes_block_o;
  logic [127:0] aes_result_i = '0;
  logic         aes_result_valid_i = 1'b0;
  logic         aes_key_ready_i = 1'b0;

  aes_stream_sequencer #(
    .TIMEOUT  (Timeout),
    .LSB_FIRST(1'b1)
  ) u_dut (
    .clk_i             (clk_i),
    .rst_i             (rst_i),
    .key_i             (key_i),
    .key_load_i        (key_load_i),
    .key_ready_o       (key_ready_o),
    .blk_valid_i       (blk_valid_i),
    .blk_data_i        (blk_data_i),
    .blk_ready_o       (blk_ready_o),
    .bit_o             (bit_o),
    .bit_valid_o       (bit_valid_o),
    .shift_en_i        (shift_en_i),
    .busy_o            (busy_o),
    .err_o             (err_o),
    .aes_reset_n_o     (aes_reset_n_o),
    .aes_init_o        (aes_init_o),
    .aes_next_o        (aes_next_o),
    .aes_key_o         (aes_key_o),
    .aes_block_o       (aes_block_o),
    .aes_result_i      (aes_result_i),
    .aes_result_valid_i(aes_result_valid_i),
    .aes_key_ready_i   (aes_key_ready_i)
  );

  always #5 clk_i = ~clk_i;

  int           n_vec = 0;
  int           n_err = 0;
  int           n_next = 0;
  int           blk_xfer = 0;
  logic [127:0] cap = '0;
  logic [127:0] tb_key = '0;
  bit           exp_q[$];
  bit           rnd_shift = 1'b0;
  bit           shift_fixed = 1'b0;
  bit           stub_hang = 1'b0;

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Stand-in for AES decryption: the known test vector, otherwise a keyed bijection.
  function automatic logic [127:0] aes_model(input logic [127:0] blk, input logic [127:0] key);
    if (blk == KnownCt && key == KnownKey) return KnownPt;
    return blk ^ {key[63:0], key[127:64]} ^ 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // aes_core stub: ready/valid keep their old value for one cycle after init/next.
  int unsigned  key_cnt = 0;
  int unsigned  res_cnt = 0;
  bit           key_busy = 1'b0;
  bit           res_busy = 1'b0;
  logic [127:0] res_pend = '0;
  always @(posedge clk_i) begin
    if (aes_reset_n_o !== 1'b1) begin
      aes_key_ready_i    <= 1'b0;
      aes_result_valid_i <= 1'b0;
      key_busy           <= 1'b0;
      res_busy           <= 1'b0;
    end else begin
      if (aes_init_o) begin
        key_busy <= 1'b1;
        key_cnt  <= $urandom_range(1, 6);
      end else if (key_busy) begin
        if (key_cnt == 0) begin
          aes_key_ready_i <= 1'b1;
          key_busy        <= 1'b0;
        end else begin
          aes_key_ready_i <= 1'b0;
          key_cnt         <= key_cnt - 1;
        end
      end
      if (aes_next_o) begin
        res_pend <= aes_model(aes_block_o, aes_key_o);
        res_cnt  <= $urandom_range(1, 8);
        res_busy <= !stub_hang;
        if (stub_hang) aes_result_valid_i <= 1'b0;
      end else if (res_busy) begin
        if (res_cnt == 0) begin
          aes_result_valid_i <= 1'b1;
          aes_result_i       <= res_pend;
          res_busy           <= 1'b0;
        end else begin
          aes_result_valid_i <= 1'b0;
          res_cnt            <= res_cnt - 1;
        end
      end
    end
  end

  initial forever begin
    @(posedge clk_i);
    #1;
    shift_en_i = rnd_shift ? 1'($urandom_range(0, 1)) : shift_fixed;
  end

  // Monitor: bit stream against the expected queue, hold stability, block acceptance.
  initial begin
    bit   hold_prev;
    logic hold_bit;
    logic [127:0] pt;
    hold_prev = 1'b0;
    hold_bit  = 1'b0;
    forever begin
      @(negedge clk_i);
      if (rst_i) begin
        hold_prev = 1'b0;
      end else begin
        if (aes_next_o) n_next++;
        if (bit_valid_o && hold_prev) check_val("bit_hold", 128'(bit_o), 128'(hold_bit));
        if (bit_valid_o && shift_en_i) begin
          if (exp_q.size() == 0) check_val("unexpected_bit", 128'(bit_valid_o), 128'(0));
          else check_val("bit", 128'(bit_o), 128'(exp_q.pop_front()));
          if (blk_xfer < 128) cap[blk_xfer] = bit_o;
          blk_xfer++;
        end
        hold_prev = bit_valid_o && !shift_en_i;
        hold_bit  = bit_o;
        if (blk_valid_i && blk_ready_o) begin
          pt = aes_model(blk_data_i, tb_key);
          for (int i = 0; i < 128; i++) exp_q.push_back(pt[i]);
          blk_xfer = 0;
          cap      = '0;
        end
      end
    end
  end

  task automatic load_key(input logic [127:0] k);
    @(posedge clk_i);
    #1;
    key_i      = k;
    tb_key     = k;
    key_load_i = 1'b1;
    @(posedge clk_i);
    #1;
    key_load_i = 1'b0;
  endtask

  task automatic wait_key();
    int n = 0;
    do begin
      @(negedge clk_i);
      n++;
    end while (!key_ready_o && n < 300);
    check_val("key_ready", 128'(key_ready_o), 128'(1));
    check_val("core_key_ready_seen", 128'(aes_key_ready_i), 128'(1));
    check_val("busy_when_ready", 128'(busy_o), 128'(0));
  endtask

  task automatic send_block(input logic [127:0] d);
    int n = 0;
    @(posedge clk_i);
    #1;
    blk_data_i  = d;
    blk_valid_i = 1'b1;
    do begin
      @(negedge clk_i);
      n++;
    end while (!blk_ready_o && n < 2000);
    check_val("blk_accept", 128'(blk_ready_o), 128'(1));
    @(posedge clk_i);
    #1;
    blk_valid_i = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while ((exp_q.size() != 0 || !blk_ready_o) && n < 3000) begin
      @(negedge clk_i);
      n++;
    end
    check_val("done_ready", 128'(blk_ready_o), 128'(1));
    check_val("done_pending", 128'(exp_q.size()), 128'(0));
    check_val("done_xfers", 128'(blk_xfer), 128'(128));
  endtask

  initial begin
    int n;
    int next0;
    logic [127:0] k2;

    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    check_val("rst_key_ready", 128'(key_ready_o), 128'(0));
    check_val("rst_blk_ready", 128'(blk_ready_o), 128'(0));
    check_val("rst_bit_valid", 128'(bit_valid_o), 128'(0));
    check_val("rst_busy", 128'(busy_o), 128'(0));
    check_val("rst_err", 128'(err_o), 128'(0));
    check_val("rst_aes_init", 128'(aes_init_o), 128'(0));
    check_val("rst_aes_next", 128'(aes_next_o), 128'(0));
    check_val("rst_aes_reset_n", 128'(aes_reset_n_o), 128'(0));
    check_val("rst_aes_key", aes_key_o, 128'(0));
    check_val("rst_aes_block", aes_block_o, 128'(0));
    rst_i = 1'b0;
    @(negedge clk_i);
    check_val("aes_rst_hold", 128'(aes_reset_n_o), 128'(0));
    @(negedge clk_i);
    check_val("aes_rst_release", 128'(aes_reset_n_o), 128'(1));

    // Block offered before any key: must wait.
    blk_data_i  = KnownCt;
    blk_valid_i = 1'b1;
    repeat (4) begin
      @(negedge clk_i);
      check_val("idle_blk_ready", 128'(blk_ready_o), 128'(0));
    end
    check_val("idle_no_next", 128'(n_next), 128'(0));
    shift_fixed = 1'b1;
    load_key(KnownKey);
    @(negedge clk_i);
    check_val("init_pulse", 128'(aes_init_o), 128'(1));
    check_val("init_busy", 128'(busy_o), 128'(1));
    @(negedge clk_i);
    check_val("init_single", 128'(aes_init_o), 128'(0));
    check_val("keywait_busy", 128'(busy_o), 128'(1));
    wait_key();
    @(posedge clk_i);
    #1;
    blk_valid_i = 1'b0;
    check_val("held_blk_accepted", 128'(exp_q.size()), 128'(128));
    wait_done();
    check_val("known_pt", cap, KnownPt);
    check_val("first_bit", 128'(cap[0]), 128'(0));
    check_val("second_bit", 128'(cap[1]), 128'(1));
    check_val("known_next_count", 128'(n_next), 128'(1));

    // Back-pressure on the same block.
    rnd_shift = 1'b1;
    next0 = n_next;
    send_block(KnownCt);
    wait_done();
    check_val("bp_pt", cap, KnownPt);
    check_val("bp_next_count", 128'(n_next - next0), 128'(1));
    rnd_shift = 1'b0;

    // Reset in the middle of shifting.
    send_block(KnownCt);
    n = 0;
    do begin
      @(negedge clk_i);
      #1;
      n++;
    end while (blk_xfer < 40 && n < 2000);
    rst_i = 1'b1;
    exp_q.delete();
    @(negedge clk_i);
    check_val("midrst_bit_valid", 128'(bit_valid_o), 128'(0));
    check_val("midrst_key_ready", 128'(key_ready_o), 128'(0));
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    repeat (3) @(negedge clk_i);
    check_val("post_rst_bit_valid", 128'(bit_valid_o), 128'(0));
    check_val("post_rst_aes_key", aes_key_o, 128'(0));
    load_key(KnownKey);
    wait_key();
    send_block(KnownCt);
    wait_done();
    check_val("rekey_pt", cap, KnownPt);

    // key_load_i and blk_valid_i together in READY: rekey wins.
    k2 = rand128();
    @(posedge clk_i);
    #1;
    key_i       = k2;
    tb_key      = k2;
    key_load_i  = 1'b1;
    blk_data_i  = rand128();
    blk_valid_i = 1'b1;
    @(negedge clk_i);
    check_val("collide_blk_ready", 128'(blk_ready_o), 128'(0));
    @(posedge clk_i);
    #1;
    key_load_i = 1'b0;
    @(negedge clk_i);
    check_val("collide_no_accept", 128'(exp_q.size()), 128'(0));
    check_val("collide_key_ready", 128'(key_ready_o), 128'(0));
    wait_key();
    @(posedge clk_i);
    #1;
    blk_valid_i = 1'b0;
    check_val("collide_late_accept", 128'(exp_q.size()), 128'(128));
    wait_done();
    check_val("collide_aes_key", aes_key_o, k2);

    // Random blocks with random back-pressure and one rekey.
    rnd_shift = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        load_key(rand128());
        wait_key();
      end
      next0 = n_next;
      send_block(rand128());
      wait_done();
      check_val("rand_next_count", 128'(n_next - next0), 128'(1));
    end
    rnd_shift = 1'b0;

    // Core never returns a result.
    stub_hang = 1'b1;
    send_block(rand128());
    @(negedge clk_i);
    check_val("to_next_pulse", 128'(aes_next_o), 128'(1));
    n = 0;
    do begin
      @(negedge clk_i);
      n++;
    end while (!err_o && n < 400);
    check_val("to_cycles", 128'(n), 128'(Timeout + 2));
    check_val("to_aes_reset_n", 128'(aes_reset_n_o), 128'(0));
    check_val("to_key_ready", 128'(key_ready_o), 128'(0));
    check_val("to_busy", 128'(busy_o), 128'(0));
    check_val("to_blk_ready", 128'(blk_ready_o), 128'(0));
    exp_q.delete();
    @(negedge clk_i);
    check_val("to_aes_reset_release", 128'(aes_reset_n_o), 128'(1));
    check_val("to_err_sticky", 128'(err_o), 128'(1));
    stub_hang = 1'b0;
    load_key(rand128());
    @(negedge clk_i);
    check_val("to_err_cleared", 128'(err_o), 128'(0));
    wait_key();
    send_block(rand128());
    wait_done();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/aes_stream_sequencer.md
Name: aes_stream_sequencer

Overview:
Sequences the shared aes_core for the PMU bitstream path. It loads the 128-bit key and runs key expansion once. It then accepts 128-bit ciphertext blocks on a valid/ready handshake, drives one decryption per block, and serialises each 128-bit plaintext result as a 1-bit programming stream toward the ccff chain head. It sits between the PMU JTAG deserialiser and aes_core, and replaces ad-hoc init/next pulsing in the PMU FSM.

Parameters:
TIMEOUT, 255, max cycles to wait for aes_key_ready_i or aes_result_valid_i before flagging an error.
LSB_FIRST, 1, 1 = bit 0 of the result is shifted out first; 0 = bit 127 first.

Ports:
clk_i  in  1  system clock, shared with aes_core.
rst_i  in  1  synchronous, active-high reset.
key_i  in  128  AES key, sampled on key_load_i.
key_load_i  in  1  one-cycle pulse: latch key_i and start key expansion.
key_ready_o  out  1  key expanded; decryptions permitted.
blk_valid_i  in  1  ciphertext block valid.
blk_data_i  in  128  ciphertext block.
blk_ready_o  out  1  sequencer accepts a block this cycle.
bit_o  out  1  serial plaintext bit.
bit_valid_o  out  1  bit_o is valid.
shift_en_i  in  1  consumer takes bit_o this cycle (advance when bit_valid_o & shift_en_i).
busy_o  out  1  high in any state except IDLE/READY.
err_o  out  1  sticky timeout error; cleared only by key_load_i or rst_i.
aes_reset_n_o  out  1  aes_core reset_n.
aes_init_o  out  1  aes_core init pulse.
aes_next_o  out  1  aes_core next pulse.
aes_key_o  out  128  latched key to aes_core.
aes_block_o  out  128  latched ciphertext to aes_core.
aes_result_i  in  128  aes_core result.
aes_result_valid_i  in  1  aes_core result_valid.
aes_key_ready_i  in  1  aes_core key_ready.

Behaviour:
- Reset (rst_i high at a clock edge):
  - state=IDLE; all outputs 0; aes_key_o/aes_block_o = 0.
  - aes_reset_n_o low while rst_i is high and for 1 cycle after.
  - Reset mid-operation aborts everything immediately; no partial bits are emitted afterward.
- States: IDLE, KEY_INIT, KEY_WAIT, READY, DEC_START, DEC_WAIT, SHIFT.
- IDLE: blk_ready_o=0. key_load_i -> latch key, clear err_o, go KEY_INIT.
- KEY_INIT: aes_init_o=1 for exactly 1 cycle -> KEY_WAIT.
- KEY_WAIT:
  - aes_key_ready_i is ignored in the first cycle (stale ready).
  - Thereafter, aes_key_ready_i=1 -> READY with key_ready_o=1.
- READY: blk_ready_o=1 (combinational from state).
  - blk_valid_i=1 -> latch blk_data_i into aes_block_o, go DEC_START.
  - key_load_i=1 -> rekey: key_ready_o=0, go KEY_INIT.
  - Both in the same cycle: key_load_i wins, block not accepted (blk_ready_o still 1 but treated as no transfer; an implementation must drop blk_ready_o when key_load_i=1).
- DEC_START: aes_next_o=1 for exactly 1 cycle -> DEC_WAIT.
- DEC_WAIT:
  - aes_result_valid_i is ignored in the first cycle.
  - Then, on aes_result_valid_i=1: capture aes_result_i into a 128-bit shift register, bit counter=0, go SHIFT.
- SHIFT:
  - bit_valid_o=1; bit_o = sr[0] (LSB_FIRST=1) or sr[127].
  - On shift_en_i: shift, counter+1.
  - Transfer with counter=127 -> READY next cycle (bit_valid_o=0).
  - No shift_en_i -> hold bit_o indefinitely (no timeout in SHIFT).
- Latency: accepted block -> first bit_valid_o = 1 (DEC_START) + aes_core latency + 1 capture cycle. Min block-to-block period = 128 shift cycles + 3 + aes latency.
- key_load_i outside IDLE/READY is ignored.
- Timeout:
  - 8-bit wait counter runs in KEY_WAIT/DEC_WAIT; counter reaching TIMEOUT -> err_o=1, key_ready_o=0.
  - aes_reset_n_o low for 1 cycle, state=IDLE.
- aes_key_o and aes_block_o hold their latched values until the next latch.

Test Plan:
- Key load: rst_i 2 cycles, key_load_i with key 2b7e151628aed2a6abf7158809cf4f3c -> aes_init_o single-cycle pulse one cycle after; key_ready_o rises after aes_core key_ready; busy_o high between.
- Decrypt: block 3ad77bb40d7a3660a89ecaf32466ef97, shift_en_i=1 -> 128 bits reassemble (LSB first) to 6bc1bee22e409f96e93d7e117393172a; first bit 0, second 1; then blk_ready_o=1.
- Back-pressure: toggle shift_en_i randomly on the same block -> identical 128-bit result, bit_o stable while shift_en_i=0, exactly 128 transfers.
- Block before key: blk_valid_i=1 in IDLE -> blk_ready_o=0, no aes_next_o, block held by source until key ready, then accepted.
- Timeout: stub aes_core, result_valid never asserted -> err_o=1 after TIMEOUT+1 DEC_WAIT cycles, aes_reset_n_o low 1 cycle, state IDLE; a subsequent key_load_i clears err_o.
- Reset mid-SHIFT after 40 bits: rst_i=1 -> bit_valid_o=0 next cycle, key_ready_o=0; after rekey, the same block yields the full 128 correct bits.
